// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared definitions for the reorder-buffer allocation controller:
// buffer geometry, controller state encoding and pointer wrap helper.
package rob_pkg;

    localparam int unsigned ROB_NUM = 64;
    localparam int unsigned ROB_SEL = 6;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } rob_ctrl_state_t;

    // Advance a ROB pointer by 0..3 entries; wraps through natural overflow.
    function automatic logic [ROB_SEL-1:0] rob_wrap_add(input logic [ROB_SEL-1:0] ptr,
                                                        input logic [1:0]         n);
        return ptr + {{(ROB_SEL-2){1'b0}}, n};
    endfunction

endpackage

// File: rtl/rob_alloc_ctrl_if.sv
// Dispatch/commit handshake between rename-dispatch and the ROB allocation
// controller. The master side is dispatch; the slave side is the controller.
interface rob_alloc_ctrl_if;
    import rob_pkg::*;

    logic               req1_i;
    logic               req2_i;
    logic [1:0]         comnum_i;
    logic               prmiss_i;
    logic               dp1_o;
    logic [ROB_SEL-1:0] dp1_addr_o;
    logic               dp2_o;
    logic [ROB_SEL-1:0] dp2_addr_o;
    logic               stall_o;
    logic [ROB_SEL-1:0] head_o;
    logic [ROB_SEL:0]   freenum_o;
    logic               empty_o;
    logic               full_o;

    modport master (
        output req1_i, req2_i, comnum_i, prmiss_i,
        input  dp1_o, dp1_addr_o, dp2_o, dp2_addr_o, stall_o,
               head_o, freenum_o, empty_o, full_o
    );

    modport slave (
        input  req1_i, req2_i, comnum_i, prmiss_i,
        output dp1_o, dp1_addr_o, dp2_o, dp2_addr_o, stall_o,
               head_o, freenum_o, empty_o, full_o
    );

endinterface

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation and flush controller: owns head/tail/occupancy, grants up to
// two dispatch slots per cycle, retires by the commit count and squashes all
// uncommitted entries on a mispredict followed by a fixed dispatch stall.
module rob_alloc_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned RECOVER_CYC = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    rob_alloc_ctrl_if.slave   bus
);

    logic [ROB_SEL-1:0] head_reg;
    logic [ROB_SEL-1:0] tail_reg;
    logic [ROB_SEL:0]   count_reg;
    rob_ctrl_state_t    state_reg;
    logic [3:0]         rcnt_reg;

    logic [ROB_SEL:0]   freenum;
    logic               grant1;
    logic               grant2;
    logic [1:0]         alloc;

    // Free space comes from registered occupancy only, so a commit this cycle
    // cannot be re-used by a grant in the same cycle.
    assign freenum = ROB_SEL'(0) + (ROB_SEL+1)'(ROB_NUM) - count_reg;

    // All-or-nothing grant: a pair is granted only if both fit, and slot 2 is
    // never granted without slot 1.
    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        if (state_reg == RUN && !bus.prmiss_i) begin
            if (bus.req1_i && bus.req2_i && freenum >= (ROB_SEL+1)'(2)) begin
                grant1 = 1'b1;
                grant2 = 1'b1;
            end else if (bus.req1_i && !bus.req2_i && freenum >= (ROB_SEL+1)'(1)) begin
                grant1 = 1'b1;
            end
        end
    end

    assign alloc          = {1'b0, grant1} + {1'b0, grant2};
    assign bus.dp1_o      = grant1;
    assign bus.dp2_o      = grant2;
    assign bus.dp1_addr_o = tail_reg;
    assign bus.dp2_addr_o = rob_wrap_add(tail_reg, 2'd1);
    assign bus.stall_o    = (bus.req1_i || bus.req2_i) && !grant1;
    assign bus.head_o     = head_reg;
    assign bus.freenum_o  = freenum;
    assign bus.empty_o    = (count_reg == '0);
    assign bus.full_o     = (count_reg == (ROB_SEL+1)'(ROB_NUM));

    // Pointer/occupancy bookkeeping plus the flush-recovery countdown.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            state_reg <= RUN;
            rcnt_reg  <= '0;
        end else if (bus.prmiss_i) begin
            // Squash everything younger than head; the ROB suppresses commit here.
            tail_reg  <= head_reg;
            count_reg <= '0;
            state_reg <= RECOVER;
            rcnt_reg  <= 4'(RECOVER_CYC - 1);
        end else if (state_reg == RUN) begin
            tail_reg  <= rob_wrap_add(tail_reg, alloc);
            head_reg  <= rob_wrap_add(head_reg, bus.comnum_i);
            count_reg <= count_reg + {{(ROB_SEL-1){1'b0}}, alloc}
                                   - {{(ROB_SEL-1){1'b0}}, bus.comnum_i};
        end else begin
            head_reg <= rob_wrap_add(head_reg, bus.comnum_i);
            if (rcnt_reg == 4'd0) begin
                state_reg <= RUN;
            end else begin
                rcnt_reg <= rcnt_reg - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Directed bench for rob_alloc_ctrl: a vector table walking fill, full and
// commit boundaries from reset, then hand sequences for wrap, flush/recover
// and asynchronous reset.
module tb_rob_alloc_ctrl;
    import rob_pkg::*;

    typedef struct {
        logic       r1;
        logic       r2;
        logic [1:0] cn;
        logic       pm;
        logic       e_dp1;
        logic       e_dp2;
        logic [5:0] e_a1;
        logic [5:0] e_a2;
        logic       e_stall;
        logic [5:0] e_head;
        logic [6:0] e_free;
        logic       e_empty;
        logic       e_full;
    } vec_t;

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    int   errors  = 0;
    int   checks  = 0;

    rob_alloc_ctrl_if bus ();

    rob_alloc_ctrl #(.RECOVER_CYC(2)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic r1, input logic r2, input int cn, input logic pm,
                                input logic d1, input logic d2, input int a1, input int a2,
                                input logic st, input int hd, input int fr,
                                input logic em, input logic fu);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.cn = 2'(cn); v.pm = pm;
        v.e_dp1 = d1; v.e_dp2 = d2; v.e_a1 = 6'(a1); v.e_a2 = 6'(a2);
        v.e_stall = st; v.e_head = 6'(hd); v.e_free = 7'(fr);
        v.e_empty = em; v.e_full = fu;
        return v;
    endfunction

    // Compare all outputs against one record at the current instant.
    task automatic compare(input string name, input vec_t v);
        logic [29:0] act;
        logic [29:0] exp;
        act = {bus.dp1_o, bus.dp2_o, bus.dp1_addr_o, bus.dp2_addr_o, bus.stall_o,
               bus.head_o, bus.freenum_o, bus.empty_o, bus.full_o};
        exp = {v.e_dp1, v.e_dp2, v.e_a1, v.e_a2, v.e_stall,
               v.e_head, v.e_free, v.e_empty, v.e_full};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got dp1=%0b dp2=%0b a1=%0d a2=%0d stall=%0b head=%0d free=%0d empty=%0b full=%0b, want dp1=%0b dp2=%0b a1=%0d a2=%0d stall=%0b head=%0d free=%0d empty=%0b full=%0b",
                     name, bus.dp1_o, bus.dp2_o, bus.dp1_addr_o, bus.dp2_addr_o, bus.stall_o,
                     bus.head_o, bus.freenum_o, bus.empty_o, bus.full_o,
                     v.e_dp1, v.e_dp2, v.e_a1, v.e_a2, v.e_stall, v.e_head, v.e_free,
                     v.e_empty, v.e_full);
        end else begin
            $display("ok   %s: a1=%0d a2=%0d dp=%0b%0b stall=%0b head=%0d free=%0d",
                     name, bus.dp1_o ? bus.dp1_addr_o : 6'd0, bus.dp2_addr_o,
                     bus.dp1_o, bus.dp2_o, bus.stall_o, bus.head_o, bus.freenum_o);
        end
    endtask

    // Apply one cycle of inputs; entered and left at posedge+1.
    task automatic drive(input logic r1, input logic r2, input int cn, input logic pm);
        bus.req1_i = r1; bus.req2_i = r2; bus.comnum_i = 2'(cn); bus.prmiss_i = pm;
        @(negedge clk_i);
        if (!pm && 7'(cn) > 7'(ROB_NUM) - bus.freenum_o)
            $display("note: stimulus commits more than occupancy (cn=%0d)", cn);
        $display("drv  r1=%0b r2=%0b cn=%0d pm=%0b", r1, r2, cn, pm);
        @(posedge clk_i);
        #1;
    endtask

    // Apply one cycle of inputs and check the outputs mid-cycle.
    task automatic step(input string name, input vec_t v);
        bus.req1_i = v.r1; bus.req2_i = v.r2; bus.comnum_i = v.cn; bus.prmiss_i = v.pm;
        @(negedge clk_i);
        compare(name, v);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        bus.req1_i = 0; bus.req2_i = 0; bus.comnum_i = 0; bus.prmiss_i = 0;
        reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    vec_t vecs[40];

    initial begin
        // Table: fill from reset, full stall, commit-then-grant, 63/64 boundary.
        vecs[0] = mk(0,0,0,0, 0,0, 0,1, 0, 0, 64, 1,0);
        for (int k = 0; k < 32; k++)
            vecs[k+1] = mk(1,1,0,0, 1,1, 2*k, 2*k+1, 0, 0, 64-2*k, (k == 0), 0);
        vecs[33] = mk(1,1,2,0, 0,0, 0,1, 1, 0, 0, 0,1);
        vecs[34] = mk(1,1,0,0, 1,1, 0,1, 0, 2, 2, 0,0);
        vecs[35] = mk(0,0,1,0, 0,0, 2,3, 0, 2, 0, 0,1);
        vecs[36] = mk(1,1,0,0, 0,0, 2,3, 1, 3, 1, 0,0);
        vecs[37] = mk(1,0,0,0, 1,0, 2,3, 0, 3, 1, 0,0);
        vecs[38] = mk(0,0,0,0, 0,0, 3,4, 0, 3, 0, 0,1);
        vecs[39] = mk(0,1,0,0, 0,0, 3,4, 1, 3, 0, 0,1);

        do_reset();
        for (int i = 0; i < 40; i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // Wrap: tail=63, head=10, pair grant with simultaneous commit of 2.
        do_reset();
        for (int i = 0; i < 31; i++) drive(1,1,0,0);
        drive(1,0,0,0);
        for (int i = 0; i < 5; i++) drive(0,0,2,0);
        step("wrap_grant", mk(1,1,2,0, 1,1, 63,0, 0, 10, 11, 0,0));
        step("wrap_after", mk(0,0,0,0, 0,0, 1,2, 0, 12, 11, 0,0));

        // Flush with count=20, head=5, then a second flush reloading recovery.
        do_reset();
        for (int i = 0; i < 10; i++) drive(1,1,0,0);
        drive(0,0,2,0); drive(0,0,2,0); drive(0,0,1,0);
        drive(1,1,0,0); drive(1,1,0,0); drive(1,0,0,0);
        step("flush_n",    mk(1,1,2,1, 0,0, 25,26, 1, 5, 44, 0,0));
        step("flush_n1",   mk(1,1,0,0, 0,0, 5,6,   1, 5, 64, 1,0));
        step("flush_n2",   mk(1,1,0,0, 0,0, 5,6,   1, 5, 64, 1,0));
        step("flush_n3",   mk(1,1,0,0, 1,1, 5,6,   0, 5, 64, 1,0));
        step("flush2_a",   mk(0,0,0,1, 0,0, 7,8,   0, 5, 62, 0,0));
        step("flush2_b",   mk(1,0,0,1, 0,0, 5,6,   1, 5, 64, 1,0));
        step("flush2_c",   mk(1,0,0,0, 0,0, 5,6,   1, 5, 64, 1,0));
        step("flush2_d",   mk(1,0,0,0, 0,0, 5,6,   1, 5, 64, 1,0));
        step("flush2_e",   mk(1,0,0,0, 1,0, 5,6,   0, 5, 64, 1,0));

        // Asynchronous reset mid-cycle with count=40.
        do_reset();
        for (int i = 0; i < 20; i++) drive(1,1,0,0);
        bus.req1_i = 0; bus.req2_i = 0; bus.comnum_i = 0; bus.prmiss_i = 0;
        #1;
        compare("pre_areset", mk(0,0,0,0, 0,0, 40,41, 0, 0, 24, 0,0));
        #1;
        reset_i = 1'b1;
        #1;
        compare("areset", mk(0,0,0,0, 0,0, 0,1, 0, 0, 64, 1,0));
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
